// File: rtl/activation_reader.sv
// Read-side sequencer for the activation buffer: walks a strided run of entries
// in one bank and streams the returned words out through a small credit-managed FIFO.
module activation_reader #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 8,
  parameter int CNT_W  = 9,
  parameter int FIFO_D = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bank,
  input  logic [IDX_W-1:0]  base_idx,
  input  logic [IDX_W-1:0]  stride,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [15:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int PTR_W = $clog2(FIFO_D);
  localparam int FCW   = $clog2(FIFO_D + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_next;
  logic               bank_q;
  logic [IDX_W-1:0]   idx, stride_q;
  logic [CNT_W-1:0]   remaining;
  logic               pending, pending_last;
  logic               done_next;
  logic               issue, pop, push, accept;
  logic [FCW:0]       credit_used;

  logic [DATA_W-1:0]  fifo_data [FIFO_D];
  logic               fifo_last [FIFO_D];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [FCW-1:0]     fifo_cnt;

  assign busy      = (state != IDLE);
  assign mem_addr  = {bank_q, 4'b0000, idx, 3'b000};
  assign out_valid = (fifo_cnt != '0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = out_valid & fifo_last[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign push      = pending;
  assign accept    = (state == IDLE) && start;

  // A read is only issued if its word is guaranteed a FIFO slot when it returns.
  assign credit_used = {1'b0, fifo_cnt} + {{FCW{1'b0}}, pending} - {{FCW{1'b0}}, pop};
  assign issue = (state == RUN) && (remaining != '0) && (credit_used < (FCW+1)'(FIFO_D));

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (count != '0)) state_next = RUN;
        else if (accept)             done_next  = 1'b1;
      end
      RUN: begin
        if (issue && (remaining == CNT_W'(1))) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      done         <= 1'b0;
      bank_q       <= 1'b0;
      idx          <= '0;
      stride_q     <= '0;
      remaining    <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
    end else begin
      state        <= state_next;
      done         <= done_next;
      pending      <= issue;
      pending_last <= issue && (remaining == CNT_W'(1));
      if (accept && (count != '0)) begin
        bank_q    <= bank;
        idx       <= base_idx;
        stride_q  <= stride;
        remaining <= count;
      end else if (issue) begin
        idx       <= idx + stride_q;
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

  // First-fall-through FIFO; the head entry is presented directly on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_D; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_last[wr_ptr] <= pending_last;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + FCW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - FCW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
